// File: rtl/scnn_scatter_accum.sv
// scnn_scatter_accum: serializes a beat of NUM_PROD products into a
// DEPTH-entry scatter-add buffer (coord all-ones skipped), then drains.
// Ports: in_valid/in_ready/op_cords/products beat input; drain_start
// pulse; drain_valid/ready/addr/data/last read-and-clear drain port;
// busy (not IDLE); dropped_cnt (saturating invalid-lane count).
// Build option: define SCNN_ACC_SAT_EN for saturating adds (else wrap).
module scnn_scatter_accum #(
    parameter int NUM_PROD = 16,
    parameter int CORD_W   = 8,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 24,
    parameter int DEPTH    = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_PROD*CORD_W-1:0] op_cords,
    input  logic [NUM_PROD*DATA_W-1:0] products,
    input  logic                       drain_start,
    output logic                       drain_valid,
    input  logic                       drain_ready,
    output logic [CORD_W-1:0]          drain_addr,
    output logic [ACC_W-1:0]           drain_data,
    output logic                       drain_last,
    output logic                       busy,
    output logic [15:0]                dropped_cnt
);
    localparam int LANE_W = $clog2(NUM_PROD);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_e;

    state_e                     state_q, state_d;
    logic [LANE_W-1:0]          lane_q, lane_d;
    logic [NUM_PROD*CORD_W-1:0] cords_q, cords_d;
    logic [NUM_PROD*DATA_W-1:0] prods_q, prods_d;
    logic [CORD_W-1:0]          drain_addr_q, drain_addr_d;
    logic [15:0]                dropped_q, dropped_d;
    logic [ACC_W-1:0]           acc_q [DEPTH];
    logic [ACC_W-1:0]           acc_d [DEPTH];

    logic                       last_lane;
    logic [CORD_W-1:0]          cur_cord;
    logic [DATA_W-1:0]          cur_prod;
    logic [ACC_W-1:0]           acc_rd;
    logic [ACC_W-1:0]           sum;

    assign last_lane = (lane_q == LANE_W'(NUM_PROD - 1));
    assign cur_cord  = cords_q[lane_q*CORD_W +: CORD_W];
    assign cur_prod  = prods_q[lane_q*DATA_W +: DATA_W];
    assign acc_rd    = acc_q[cur_cord];

    assign in_ready    = (state_q == IDLE && !drain_start) ||
                         (state_q == SCAN && last_lane);
    assign busy        = (state_q != IDLE);
    assign drain_valid = (state_q == DRAIN);
    assign drain_addr  = drain_addr_q;
    assign drain_data  = acc_q[drain_addr_q];
    assign drain_last  = drain_valid &&
                         (drain_addr_q == CORD_W'(DEPTH - 1));
    assign dropped_cnt = dropped_q;

`ifdef SCNN_ACC_SAT_EN
    // One guard bit detects signed overflow of the add.
    logic [ACC_W:0] sum_wide;
    always_comb begin
        sum_wide = {acc_rd[ACC_W-1], acc_rd} +
                   {{(ACC_W+1-DATA_W){cur_prod[DATA_W-1]}}, cur_prod};
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sum = sum_wide[ACC_W-1:0];
        end
    end
`else
    always_comb begin
        sum = acc_rd + {{(ACC_W-DATA_W){cur_prod[DATA_W-1]}}, cur_prod};
    end
`endif

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        cords_d      = cords_q;
        prods_d      = prods_q;
        drain_addr_d = drain_addr_q;
        dropped_d    = dropped_q;
        acc_d        = acc_q;
        unique case (state_q)
            IDLE: begin
                if (drain_start) begin
                    state_d      = DRAIN;
                    drain_addr_d = '0;
                    dropped_d    = '0;
                end else if (in_valid) begin
                    state_d = SCAN;
                    lane_d  = '0;
                    cords_d = op_cords;
                    prods_d = products;
                end
            end
            SCAN: begin
                if (cur_cord == '1) begin
                    if (dropped_q != '1) begin
                        dropped_d = dropped_q + 16'd1;
                    end
                end else begin
                    acc_d[cur_cord] = sum;
                end
                if (last_lane) begin
                    // Back-to-back beat: recapture with no bubble.
                    if (in_valid) begin
                        lane_d  = '0;
                        cords_d = op_cords;
                        prods_d = products;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_ready) begin
                    acc_d[drain_addr_q] = '0;
                    drain_addr_d        = drain_addr_q + 1'b1;
                    if (drain_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            cords_q      <= '0;
            prods_q      <= '0;
            drain_addr_q <= '0;
            dropped_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            cords_q      <= cords_d;
            prods_q      <= prods_d;
            drain_addr_q <= drain_addr_d;
            dropped_q    <= dropped_d;
            acc_q        <= acc_d;
        end
    end

endmodule

// File: tb/tb_scnn_scatter_accum.sv
// tb_scnn_scatter_accum: random and directed beats/drains checked every
// cycle against a beat-level behavioural model of the accumulator.
module tb_scnn_scatter_accum;
    localparam int NP = 16;
    localparam int CW = 8;
    localparam int DW = 16;
    localparam int AW = 24;
    localparam int D  = 256;
    localparam longint AMAX = (longint'(1) << (AW - 1)) - 1;
    localparam longint AMIN = -(longint'(1) << (AW - 1));
    localparam longint AMOD = longint'(1) << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic drain_start = 1'b0;
    logic drain_ready = 1'b0;
    logic in_ready, drain_valid, drain_last, busy;
    logic [NP*CW-1:0] op_cords = '0;
    logic [NP*DW-1:0] products = '0;
    logic [CW-1:0] drain_addr;
    logic [AW-1:0] drain_data;
    logic [15:0] dropped_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scnn_scatter_accum dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_cords(op_cords), .products(products),
        .drain_start(drain_start), .drain_valid(drain_valid),
        .drain_ready(drain_ready), .drain_addr(drain_addr),
        .drain_data(drain_data), .drain_last(drain_last),
        .busy(busy), .dropped_cnt(dropped_cnt)
    );

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out", nm);
    endtask

    // ---------------- behavioural model ----------------
    longint m_acc [D];
    int m_mode;   // 0 idle, 1 scanning, 2 draining
    int m_left;   // lanes of current beat still to be serialized
    int m_addr;
    int m_drop;

    function automatic longint addw(input longint a, input longint p);
        longint s;
        s = a + p;
`ifdef SCNN_ACC_SAT_EN
        if (s > AMAX) s = AMAX;
        if (s < AMIN) s = AMIN;
`else
        s = s % AMOD;
        if (s < 0) s += AMOD;
        if (s > AMAX) s -= AMOD;
`endif
        return s;
    endfunction

    task automatic m_accept();
        for (int k = 0; k < NP; k++) begin
            logic [CW-1:0] c;
            c = op_cords[k*CW +: CW];
            if (c == 8'hFF) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                m_acc[c] = addw(m_acc[c],
                                longint'($signed(products[k*DW +: DW])));
            end
        end
        m_mode = 1;
        m_left = NP;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) m_acc[i] = 0;
            m_mode = 0;
            m_left = 0;
            m_addr = 0;
            m_drop = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (drain_start) begin
                        m_mode = 2;
                        m_addr = 0;
                        m_drop = 0;
                    end else if (in_valid) begin
                        m_accept();
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (in_valid) m_accept();
                        else m_mode = 0;
                    end
                end
                default: begin
                    if (drain_ready) begin
                        m_acc[m_addr] = 0;
                        if (m_addr == D - 1) m_mode = 0;
                        m_addr = (m_addr + 1) % D;
                    end
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready,
                (m_mode == 0 && !drain_start) ||
                (m_mode == 1 && m_left == 1));
            chk("busy", busy, m_mode != 0);
            chk("drain_valid", drain_valid, m_mode == 2);
            chk("drain_addr", drain_addr, m_addr);
            chk("drain_last", drain_last,
                m_mode == 2 && m_addr == D - 1);
            if (m_mode == 2)
                chk("drain_data", $signed(drain_data), m_acc[m_addr]);
            if (m_mode != 1)
                chk("dropped_cnt", dropped_cnt, m_drop);
        end
    end

    // ---------------- drivers ----------------
    logic [CW-1:0] bc [NP];
    logic [DW-1:0] bp [NP];
    longint got [D];
    int nwords, nlast, lastaddr, nonzero;

    task automatic send_beat(output int waits);
        for (int k = 0; k < NP; k++) begin
            op_cords[k*CW +: CW] = bc[k];
            products[k*DW +: DW] = bp[k];
        end
        in_valid = 1'b1;
        waits = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            waits++;
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        fail("beat accept");
    endtask

    task automatic wait_idle();
        in_valid = 1'b0;
        drain_start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        fail("wait idle");
    endtask

    task automatic do_drain(input int stall_at, input int rst_at,
                            input bit rnd);
        int stall;
        bit done;
        wait_idle();
        for (int i = 0; i < D; i++) got[i] = 0;
        nwords = 0;
        nlast = 0;
        lastaddr = -1;
        nonzero = 0;
        stall = 0;
        done = 1'b0;
        drain_start = 1'b1;
        op_cords = {4{$urandom()}};
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk);
        #1;
        drain_start = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            drain_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rnd) in_valid = 1'($urandom_range(0, 1));
            if (int'(drain_addr) == stall_at && stall < 3) begin
                drain_ready = 1'b0;
                stall++;
            end
            @(negedge clk);
            if (c == 0) chk("dropped cleared", dropped_cnt, 0);
            if (rst_at >= 0 && int'(drain_addr) == rst_at) begin
                in_valid = 1'b0;
                #1 rst_n = 1'b0;
                #1;
                chk("reset drain_valid", drain_valid, 0);
                chk("reset drain_addr", drain_addr, 0);
                #1 rst_n = 1'b1;
                done = 1'b1;
            end else if (drain_valid && drain_ready) begin
                got[drain_addr] = $signed(drain_data);
                nwords++;
                if (drain_data != '0) nonzero++;
                if (drain_last) begin
                    nlast++;
                    lastaddr = int'(drain_addr);
                    in_valid = 1'b0;
                    done = 1'b1;
                end
            end
            if (!done) begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) fail("drain");
        @(posedge clk);
        #1;
        drain_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int w;
        #12;
        chk("reset busy", busy, 0);
        chk("reset drain_valid", drain_valid, 0);
        chk("reset drain_last", drain_last, 0);
        chk("reset dropped", dropped_cnt, 0);
        chk("reset drain_addr", drain_addr, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready after reset", in_ready, 1);

        // Empty drain
        do_drain(-1, -1, 1'b0);
        chk("empty words", nwords, 256);
        chk("empty last count", nlast, 1);
        chk("empty last addr", lastaddr, 255);
        chk("empty nonzero", nonzero, 0);
        wait_idle();
        chk("busy after drain", busy, 0);

        // Coords 0..15, products 1..16
        for (int k = 0; k < NP; k++) begin
            bc[k] = CW'(k);
            bp[k] = DW'(k + 1);
        end
        send_beat(w);
        do_drain(-1, -1, 1'b0);
        for (int k = 0; k < NP; k++) chk("ramp acc", got[k], k + 1);
        chk("ramp nonzero", nonzero, 16);
        do_drain(-1, -1, 1'b0);
        chk("second drain nonzero", nonzero, 0);

        // Back-to-back, coord 5, product 100
        for (int k = 0; k < NP; k++) begin
            bc[k] = 8'h05;
            bp[k] = 16'd100;
        end
        send_beat(w);
        send_beat(w);
        chk("b2b accept cycle", w, 16);
        do_drain(-1, -1, 1'b0);
        chk("b2b acc5", got[5], 3200);

        // Invalid lanes 3, 7, 9
        for (int k = 0; k < NP; k++) begin
            bc[k] = (k == 3 || k == 7 || k == 9) ? 8'hFF : 8'h02;
            bp[k] = 16'hFFFC;
        end
        send_beat(w);
        wait_idle();
        chk("dropped 3", dropped_cnt, 3);
        do_drain(-1, -1, 1'b0);
        chk("neg acc2", got[2], -52);

        // 300 beats of 32767 into coord 3
        for (int k = 0; k < NP; k++) begin
            bc[k] = 8'h03;
            bp[k] = 16'd32767;
        end
        for (int b = 0; b < 300; b++) send_beat(w);
        do_drain(-1, -1, 1'b0);
`ifdef SCNN_ACC_SAT_EN
        chk("big acc3", got[3], 8388607);
`else
        chk("big acc3", got[3], 6286656);
`endif

        // Stall at 10, reset at 20
        for (int k = 0; k < NP; k++) begin
            bc[k] = CW'($urandom_range(0, 40));
            bp[k] = DW'($urandom);
        end
        send_beat(w);
        do_drain(10, -1, 1'b0);
        chk("stall words", nwords, 256);
        send_beat(w);
        do_drain(-1, 20, 1'b0);
        do_drain(-1, -1, 1'b0);
        chk("post reset nonzero", nonzero, 0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            int nb;
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                for (int k = 0; k < NP; k++) begin
                    bc[k] = ($urandom_range(0, 7) == 0) ? 8'hFF
                            : CW'($urandom_range(0, 24));
                    bp[k] = DW'($urandom);
                end
                send_beat(w);
                if ($urandom_range(0, 2) == 0) begin
                    repeat ($urandom_range(1, 20)) @(posedge clk);
                    #1;
                end
            end
            do_drain(-1, -1, 1'b1);
            chk("random words", nwords, 256);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        fail("global watchdog");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
